// File: rtl/uart_cfg_sequencer.sv
`timescale 1ns/1ps
// uart_cfg_sequencer
// Brings up a 16550-style UART over its Wishbone classic slave port. On an
// accepted start it programs the divisor latch, frame format, FIFO control
// and interrupt enable registers, then reads LCR back to confirm.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, async active-low reset
//   start_i                       one-cycle run request (IDLE only)
//   divisor_i, lcr_fmt_i,
//   fcr_i, ier_i                  configuration, latched on accepted start
//   wb_addr_o .. wb_cyc_o,
//   wb_dat_i, wb_ack_i            Wishbone classic master port
//   busy_o, done_o, err_o,
//   err_step_o                    sequence status (held until next start)
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for start_i; status outputs hold the last result
// S_REQ      | first strobe cycle of the current step, bus already driven
// S_WAIT_ACK | strobe held, waiting for ack or the timeout
// S_GAP      | one idle bus cycle between steps; final readback check
// S_DONE     | sequence finished cleanly, back to IDLE next edge
// S_ERR      | sequence aborted, back to IDLE next edge

module uart_cfg_sequencer #(
  parameter int ACK_TIMEOUT = 16,
  parameter int STEP_W      = 3
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [15:0]       divisor_i,
  input  logic [7:0]        lcr_fmt_i,
  input  logic [7:0]        fcr_i,
  input  logic [7:0]        ier_i,
  output logic [4:0]        wb_addr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic [31:0]       wb_dat_i,
  output logic              wb_we_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [STEP_W-1:0] err_step_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
  } req_t;

  localparam logic [STEP_W-1:0] ST_LCR_DLAB = STEP_W'(1);
  localparam logic [STEP_W-1:0] ST_DLL      = STEP_W'(2);
  localparam logic [STEP_W-1:0] ST_DLM      = STEP_W'(3);
  localparam logic [STEP_W-1:0] ST_LCR      = STEP_W'(4);
  localparam logic [STEP_W-1:0] ST_FCR      = STEP_W'(5);
  localparam logic [STEP_W-1:0] ST_IER      = STEP_W'(6);
  localparam logic [STEP_W-1:0] ST_READ     = STEP_W'(7);

  localparam logic [4:0] REG_DLL = 5'd0;
  localparam logic [4:0] REG_DLM = 5'd1;
  localparam logic [4:0] REG_IER = 5'd1;
  localparam logic [4:0] REG_FCR = 5'd2;
  localparam logic [4:0] REG_LCR = 5'd3;

  // REQ already counts as the first strobe cycle, so the down-counter only
  // has to cover the remaining ACK_TIMEOUT-1 cycles spent in WAIT_ACK.
  localparam logic [7:0] TMR_LOAD = (ACK_TIMEOUT >= 2) ? 8'(ACK_TIMEOUT - 2) : 8'd0;

  state_t            state_q;
  logic [STEP_W-1:0] step_q;
  logic [15:0]       div_q;
  logic [6:0]        fmt_q;
  logic [7:0]        fcr_q;
  logic [7:0]        ier_q;
  logic [7:0]        rd_q;
  logic [7:0]        tmr_q;
  req_t              nxt_req;

  logic unused_bits;
  assign unused_bits = ^{wb_dat_i[31:8], lcr_fmt_i[7]};

  function automatic req_t step_req(input logic [STEP_W-1:0] s,
                                    input logic [15:0]       div,
                                    input logic [6:0]        fmt,
                                    input logic [7:0]        fcr,
                                    input logic [7:0]        ier);
    req_t r;
    r = '0;
    case (s)
      ST_LCR_DLAB: r = '{we: 1'b1, addr: REG_LCR, data: {1'b1, fmt}};
      ST_DLL:      r = '{we: 1'b1, addr: REG_DLL, data: div[7:0]};
      ST_DLM:      r = '{we: 1'b1, addr: REG_DLM, data: div[15:8]};
      ST_LCR:      r = '{we: 1'b1, addr: REG_LCR, data: {1'b0, fmt}};
      ST_FCR:      r = '{we: 1'b1, addr: REG_FCR, data: fcr};
      ST_IER:      r = '{we: 1'b1, addr: REG_IER, data: ier};
      ST_READ:     r = '{we: 1'b0, addr: REG_LCR, data: 8'h00};
      default:     r = '0;
    endcase
    return r;
  endfunction

  // The bus is driven on the edge that enters REQ. From IDLE the config
  // registers are being loaded on that same edge, so step 1 is built
  // straight from the inputs.
  always_comb begin
    nxt_req = '0;
    if (state_q == S_IDLE)
      nxt_req = step_req(ST_LCR_DLAB, divisor_i, lcr_fmt_i[6:0], fcr_i, ier_i);
    else
      nxt_req = step_req(step_q + STEP_W'(1), div_q, fmt_q, fcr_q, ier_q);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      div_q      <= '0;
      fmt_q      <= '0;
      fcr_q      <= '0;
      ier_q      <= '0;
      rd_q       <= '0;
      tmr_q      <= '0;
      wb_addr_o  <= '0;
      wb_sel_o   <= '0;
      wb_dat_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_step_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            div_q      <= divisor_i;
            fmt_q      <= lcr_fmt_i[6:0];
            fcr_q      <= fcr_i;
            ier_q      <= ier_i;
            step_q     <= ST_LCR_DLAB;
            done_o     <= 1'b0;
            err_step_o <= '0;
            if (divisor_i == 16'h0000) begin
              // A zero divisor would stop the baud generator; refuse it
              // before touching the UART.
              err_o   <= 1'b1;
              state_q <= S_ERR;
            end else begin
              err_o     <= 1'b0;
              busy_o    <= 1'b1;
              wb_cyc_o  <= 1'b1;
              wb_stb_o  <= 1'b1;
              wb_sel_o  <= 4'b0001;
              wb_we_o   <= nxt_req.we;
              wb_addr_o <= nxt_req.addr;
              wb_dat_o  <= {24'h0, nxt_req.data};
              state_q   <= S_REQ;
            end
          end
        end

        S_REQ: begin
          tmr_q   <= TMR_LOAD;
          state_q <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (wb_ack_i) begin
            if (!wb_we_o) rd_q <= wb_dat_i[7:0];
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_sel_o  <= '0;
            wb_we_o   <= 1'b0;
            wb_addr_o <= '0;
            wb_dat_o  <= '0;
            state_q   <= S_GAP;
          end else if (tmr_q == 8'd0) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_addr_o  <= '0;
            wb_dat_o   <= '0;
            busy_o     <= 1'b0;
            err_o      <= 1'b1;
            err_step_o <= step_q;
            state_q    <= S_ERR;
          end else begin
            tmr_q <= tmr_q - 8'd1;
          end
        end

        S_GAP: begin
          if (step_q == ST_READ) begin
            busy_o <= 1'b0;
            if (rd_q == {1'b0, fmt_q}) begin
              done_o  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_o      <= 1'b1;
              err_step_o <= ST_READ;
              state_q    <= S_ERR;
            end
          end else begin
            step_q    <= step_q + STEP_W'(1);
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            wb_sel_o  <= 4'b0001;
            wb_we_o   <= nxt_req.we;
            wb_addr_o <= nxt_req.addr;
            wb_dat_o  <= {24'h0, nxt_req.data};
            state_q   <= S_REQ;
          end
        end

        S_DONE:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
`timescale 1ns/1ps
// Bench for uart_cfg_sequencer: a scripted Wishbone slave (per-step ack
// delay, per-step silence, programmable readback) plus a bus monitor. The
// expected register writes, final status and edge counts are worked out
// from the register map and per-step cycle costs.
module tb_uart_cfg_sequencer;

  localparam int ACK_TO = 16;

  typedef struct packed {
    logic [4:0] addr;
    logic       we;
    logic [7:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] div = '0;
  logic [7:0]  fmt = '0, fcr = '0, ier = '0;
  logic [4:0]  addr;
  logic [3:0]  sel;
  logic [31:0] dat_o, dat_i;
  logic        we, stb, cyc, ack;
  logic        busy, done, err;
  logic [2:0]  err_step;

  uart_cfg_sequencer #(.ACK_TIMEOUT(ACK_TO), .STEP_W(3)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .start_i(start),
    .divisor_i(div), .lcr_fmt_i(fmt), .fcr_i(fcr), .ier_i(ier),
    .wb_addr_o(addr), .wb_sel_o(sel), .wb_dat_o(dat_o), .wb_dat_i(dat_i),
    .wb_we_o(we), .wb_stb_o(stb), .wb_cyc_o(cyc), .wb_ack_i(ack),
    .busy_o(busy), .done_o(done), .err_o(err), .err_step_o(err_step)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scripted slave ----------------
  int         nak_step = 0;
  int         dly_step = 0;
  int         dly = 0;
  logic [7:0] rd_val = '0;
  int         wcnt;
  txn_t       obs_q[$];

  assign dat_i = {24'hA5A5A5, rd_val};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      wcnt <= 0;
    end else if (cyc && stb && !ack) begin
      if (obs_q.size() + 1 == nak_step) begin
        ack <= 1'b0;
      end else if (wcnt >= ((obs_q.size() + 1 == dly_step) ? dly : 0)) begin
        ack  <= 1'b1;
        wcnt <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      ack  <= 1'b0;
      wcnt <= 0;
    end
  end

  // ---------------- bus monitor ----------------
  int          proto_bad = 0;
  int          run_len = 0;
  int          max_run = 0;
  bit          cyc_seen = 0;
  bit          prev_stb = 0, prev_ack = 0;
  logic [37:0] prev_sig = '0;

  always @(negedge clk) begin
    if (cyc) cyc_seen = 1;
    if (stb) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (!cyc || sel != 4'b0001 || dat_o[31:8] != 24'h0) proto_bad++;
      if (prev_stb && !prev_ack && {addr, we, dat_o} != prev_sig) proto_bad++;
      if (ack) obs_q.push_back(txn_t'{addr, we, we ? dat_o[7:0] : 8'h00});
    end else begin
      run_len = 0;
      if (cyc || sel != 4'h0 || we || addr != 5'd0 || dat_o != 32'h0) proto_bad++;
    end
    prev_stb = stb;
    prev_ack = ack;
    prev_sig = {addr, we, dat_o};
  end

  task automatic clear_mon();
    obs_q.delete();
    proto_bad = 0;
    run_len   = 0;
    max_run   = 0;
    cyc_seen  = 0;
  endtask

  // ---------------- reference model ----------------
  txn_t exp_q[$];

  function automatic void build_exp(input logic [15:0] d, input logic [7:0] f,
                                    input logic [7:0] c, input logic [7:0] i);
    logic [7:0] f7;
    f7 = {1'b0, f[6:0]};
    exp_q.delete();
    exp_q.push_back(txn_t'{5'd3, 1'b1, f7 | 8'h80});  // LCR with DLAB
    exp_q.push_back(txn_t'{5'd0, 1'b1, d[7:0]});      // DLL
    exp_q.push_back(txn_t'{5'd1, 1'b1, d[15:8]});     // DLM
    exp_q.push_back(txn_t'{5'd3, 1'b1, f7});          // LCR
    exp_q.push_back(txn_t'{5'd2, 1'b1, c});           // FCR
    exp_q.push_back(txn_t'{5'd1, 1'b1, i});           // IER
    exp_q.push_back(txn_t'{5'd3, 1'b0, 8'h00});       // LCR readback
  endfunction

  // Launch a sequence; returns one tick after the accepting edge.
  task automatic launch(input logic [15:0] d, input logic [7:0] f,
                        input logic [7:0] c, input logic [7:0] i);
    @(posedge clk); #1;
    div = d; fmt = f; fcr = c; ier = i;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // config must have been latched; scramble the inputs
    div = 16'($urandom); fmt = 8'($urandom); fcr = 8'($urandom); ier = 8'($urandom);
  endtask

  task automatic run_case(input string name, input logic [15:0] d, input logic [7:0] f,
                          input logic [7:0] c, input logic [7:0] i,
                          input int nak, input int dstep, input int dl,
                          input logic [7:0] rv, input int pulse_at);
    int   n;
    int   exp_ntx, exp_cyc, exp_run, exp_es;
    bit   exp_done, exp_err;
    txn_t o, e;

    build_exp(d, f, c, i);
    if (d == 16'h0) begin
      exp_ntx = 0; exp_cyc = 0; exp_run = 0; exp_done = 0; exp_err = 1; exp_es = 0;
    end else if (nak >= 1 && nak <= 7) begin
      exp_ntx = nak - 1; exp_cyc = 3 * (nak - 1) + ACK_TO; exp_run = ACK_TO;
      exp_done = 0; exp_err = 1; exp_es = nak;
    end else begin
      exp_ntx = 7;
      exp_cyc = 21 + ((dstep >= 1 && dstep <= 7) ? dl : 0);
      exp_run = 2 + ((dstep >= 1 && dstep <= 7) ? dl : 0);
      if (rv == {1'b0, f[6:0]}) begin
        exp_done = 1; exp_err = 0; exp_es = 0;
      end else begin
        exp_done = 0; exp_err = 1; exp_es = 7;
      end
    end

    nak_step = nak; dly_step = dstep; dly = dl; rd_val = rv;
    clear_mon();
    launch(d, f, c, i);
    check({name, ".busy_after_start"}, busy, (d != 16'h0));

    n = 0;
    while (!(done || err) && n < 300) begin
      @(posedge clk); #1;
      n++;
      start = (n == pulse_at);
    end
    start = 1'b0;
    check({name, ".edges_to_status"}, n, exp_cyc);
    check({name, ".done"}, done, exp_done);
    check({name, ".err"}, err, exp_err);
    if (exp_err) check({name, ".err_step"}, err_step, exp_es);
    check({name, ".busy_end"}, busy, 0);

    repeat (4) @(posedge clk);
    #1;
    check({name, ".status_held"}, {done, err}, {exp_done, exp_err});
    check({name, ".txn_count"}, obs_q.size(), exp_ntx);
    for (int k = 0; k < exp_ntx && k < obs_q.size(); k++) begin
      o = obs_q[k];
      e = exp_q[k];
      check($sformatf("%s.txn%0d", name, k + 1), o, e);
    end
    check({name, ".max_stb_run"}, max_run, exp_run);
    check({name, ".cyc_seen"}, cyc_seen, (d != 16'h0));
    check({name, ".bus_protocol"}, proto_bad, 0);
  endtask

  initial begin
    int         nak, dstep, dl;
    logic [15:0] d;
    logic [7:0]  f, c, i, rv;

    // reset state
    #2;
    check("reset.outputs", {addr, sel, dat_o, we, stb, cyc, busy, done, err, err_step}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_case("nominal", 16'h0145, 8'h03, 8'hC7, 8'h01, 0, 0, 0, 8'h03, -1);
    run_case("wait5_step3", 16'h0145, 8'h03, 8'hC7, 8'h01, 0, 3, 5, 8'h03, -1);
    run_case("timeout_step5", 16'h0145, 8'h03, 8'hC7, 8'h01, 5, 0, 0, 8'h03, -1);
    run_case("readback_bad", 16'h0145, 8'h03, 8'hC7, 8'h01, 0, 0, 0, 8'h83, -1);
    run_case("start_in_step2", 16'h1234, 8'h1B, 8'h07, 8'h0F, 0, 0, 0, 8'h1B, 4);
    run_case("div_zero", 16'h0000, 8'h03, 8'hC7, 8'h01, 0, 0, 0, 8'h03, -1);

    // reset while step 4 waits for ack
    nak_step = 4; dly_step = 0; dly = 0; rd_val = 8'h03;
    clear_mon();
    launch(16'h0145, 8'h03, 8'hC7, 8'h01);
    repeat (11) @(posedge clk);
    #1;
    check("rst_mid.in_step4", {stb, 5'(obs_q.size())}, {1'b1, 5'd3});
    rst_n = 1'b0;
    #1;
    check("rst_mid.async_clear", {cyc, stb, busy, done, err, err_step}, '0);
    @(posedge clk); #1;
    check("rst_mid.held_clear", {cyc, stb, busy, done, err, err_step}, '0);
    rst_n = 1'b1;
    run_case("after_reset", 16'h0145, 8'h03, 8'hC7, 8'h01, 0, 0, 0, 8'h03, -1);

    // randomized configurations
    for (int it = 0; it < 8; it++) begin
      d     = 16'($urandom_range(1, 65535));
      f     = 8'($urandom);
      c     = 8'($urandom);
      i     = 8'($urandom);
      dstep = $urandom_range(1, 7);
      dl    = $urandom_range(0, 3);
      nak   = (it % 3 == 2) ? $urandom_range(1, 7) : 0;
      rv    = (it % 4 == 3) ? 8'({1'b1, f[6:0]}) : 8'({1'b0, f[6:0]});
      run_case($sformatf("rand%0d", it), d, f, c, i, nak, dstep, dl, rv, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
